// File: rtl/icache_pkg.sv
// Shared types and helpers for the L1 instruction-cache miss/fill sequencer.
package icache_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        SENT = 2'd2
    } entry_state_t;

    // fill_resp bit that marks a valid data return; when clear the fill is a retry
    localparam int unsigned RESP_VALID_BIT = 0;

    function automatic int unsigned line_width(input int unsigned nphys,
                                               input int unsigned line_size);
        return nphys - line_size;
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_rr_pick.sv
// Rotating-priority picker: first set request at or after start, wrapping (N power of two).
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = start + IW'(k);
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Miss/fill sequencer for the L1 I-cache: merges fetch misses into a small MSHR table,
// issues one L2 line request per cycle and retires entries on returning fills.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned NPHYS            = 56,
    parameter int unsigned ACACHE_LINE_SIZE = 6,
    parameter int unsigned NMISS            = 4,
    parameter int unsigned TRANS_ID_SIZE    = 6,
    localparam int unsigned LW = line_width(NPHYS, ACACHE_LINE_SIZE),
    localparam int unsigned IW = $clog2(NMISS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss0_req,
    input  logic [LW-1:0]            miss0_addr,
    output logic                     miss0_ack,
    input  logic                     miss1_req,
    input  logic [LW-1:0]            miss1_addr,
    output logic                     miss1_ack,
    output logic                     l2_req,
    output logic [LW-1:0]            l2_addr,
    output logic [TRANS_ID_SIZE-1:0] l2_trid,
    input  logic                     l2_ack,
    input  logic                     fill_req,
    input  logic [TRANS_ID_SIZE-1:0] fill_trid,
    input  logic [2:0]               fill_resp,
    output logic                     fill_done,
    output logic [LW-1:0]            fill_addr,
    output logic                     busy
);

    entry_state_t  st       [NMISS];
    logic [LW-1:0] ent_addr [NMISS];
    logic [IW-1:0] slot_idx;
    logic [IW-1:0] issue_ptr;
    logic          last_win1;

    logic [NMISS-1:0] free_vec, pend_base, issue_vec, free_grant, iss_grant;
    logic [IW-1:0]    free_idx, iss_idx, fill_idx;
    logic             free_valid, iss_valid;
    logic             hit0, hit1, need0, need1, same_line, contest;
    logic             alloc_port0, alloc_port1, alloc, load, iss_is_alloc;
    logic             fill_sent, fill_ok, fill_retry;
    logic [LW-1:0]    alloc_addr, iss_addr;
    logic             unused_resp_bits;

    assign unused_resp_bits = ^fill_resp[2:1];

    always_comb begin
        free_vec  = '0;
        pend_base = '0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        busy      = 1'b0;
        for (int unsigned i = 0; i < NMISS; i++) begin
            free_vec[i]  = (st[i] == FREE);
            // the entry already sitting in the request slot must not be loaded twice
            pend_base[i] = (st[i] == PEND) && !(l2_req && slot_idx == IW'(i));
            if (st[i] != FREE) begin
                busy = 1'b1;
                if (ent_addr[i] == miss0_addr) hit0 = 1'b1;
                if (ent_addr[i] == miss1_addr) hit1 = 1'b1;
            end
        end
    end

    rr_pick #(.N(NMISS)) u_free_pick (
        .req   (free_vec),
        .start ('0),
        .grant (free_grant),
        .idx   (free_idx),
        .valid (free_valid)
    );

    assign need0       = miss0_req && !hit0;
    assign need1       = miss1_req && !hit1;
    assign same_line   = need0 && need1 && (miss0_addr == miss1_addr);
    assign contest     = need0 && need1 && !same_line;
    assign alloc_port1 = need1 && (!need0 || (contest && !last_win1));
    assign alloc_port0 = need0 && !alloc_port1;
    assign alloc       = free_valid && (need0 || need1);
    assign alloc_addr  = alloc_port1 ? miss1_addr : miss0_addr;

    assign miss0_ack = miss0_req && (hit0 || (free_valid && alloc_port0));
    assign miss1_ack = miss1_req && (hit1 || (free_valid && (alloc_port1 || same_line)));

    // a line allocated this cycle is visible to issue selection so l2_req can rise next cycle
    assign issue_vec = pend_base | (alloc ? free_grant : '0);
    assign load      = !l2_req || l2_ack;

    rr_pick #(.N(NMISS)) u_issue_pick (
        .req   (issue_vec),
        .start (issue_ptr),
        .grant (iss_grant),
        .idx   (iss_idx),
        .valid (iss_valid)
    );

    assign iss_is_alloc = alloc && |(iss_grant & free_grant);
    assign iss_addr     = iss_is_alloc ? alloc_addr : ent_addr[iss_idx];

    assign fill_idx   = fill_trid[IW-1:0];
    assign fill_sent  = fill_req && ((fill_trid >> IW) == '0) && (st[fill_idx] == SENT);
    assign fill_ok    = fill_sent && fill_resp[RESP_VALID_BIT];
    assign fill_retry = fill_sent && !fill_resp[RESP_VALID_BIT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NMISS; i++) begin
                st[i]       <= FREE;
                ent_addr[i] <= '0;
            end
            slot_idx  <= '0;
            issue_ptr <= '0;
            last_win1 <= 1'b0;
            l2_req    <= 1'b0;
            l2_addr   <= '0;
            l2_trid   <= '0;
            fill_done <= 1'b0;
            fill_addr <= '0;
        end else begin
            fill_done <= fill_ok;
            if (fill_ok) begin
                st[fill_idx] <= FREE;
                fill_addr    <= ent_addr[fill_idx];
            end
            if (fill_retry) st[fill_idx] <= PEND;
            if (alloc) begin
                st[free_idx]       <= PEND;
                ent_addr[free_idx] <= alloc_addr;
                if (contest) last_win1 <= alloc_port1;
            end
            if (l2_req && l2_ack) st[slot_idx] <= SENT;
            if (load) begin
                l2_req <= iss_valid;
                if (iss_valid) begin
                    l2_addr   <= iss_addr;
                    l2_trid   <= TRANS_ID_SIZE'(iss_idx);
                    slot_idx  <= iss_idx;
                    issue_ptr <= iss_idx + 1'b1;
                end
            end
        end
    end

    a_fill_to_sent: assert property (@(posedge clk) disable iff (!reset) fill_req |-> fill_sent);

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed and randomized checks of icache_fill_ctrl against a table-level miss/fill model.
module tb_icache_fill_ctrl;

    localparam int LW = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss0_req, miss1_req, miss0_ack, miss1_ack;
    logic [LW-1:0] miss0_addr, miss1_addr, l2_addr, fill_addr;
    logic          l2_req, l2_ack, fill_req, fill_done, busy;
    logic [5:0]    l2_trid, fill_trid;
    logic [2:0]    fill_resp;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl #(.NPHYS(56), .ACACHE_LINE_SIZE(6), .NMISS(4), .TRANS_ID_SIZE(6)) dut (
        .clk(clk), .reset(reset),
        .miss0_req(miss0_req), .miss0_addr(miss0_addr), .miss0_ack(miss0_ack),
        .miss1_req(miss1_req), .miss1_addr(miss1_addr), .miss1_ack(miss1_ack),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_trid(l2_trid), .l2_ack(l2_ack),
        .fill_req(fill_req), .fill_trid(fill_trid), .fill_resp(fill_resp),
        .fill_done(fill_done), .fill_addr(fill_addr), .busy(busy)
    );

    // Reference model: entry table (0=free, 1=waiting for L2, 2=at L2) plus request slot
    int            m_st[4], n_st[4];
    logic [LW-1:0] m_addr[4], n_addr[4];
    int            m_ptr, n_ptr, m_slot, n_slot, m_trid, n_trid;
    bit            m_last1, n_last1, m_req, n_req, m_done, n_done;
    logic [LW-1:0] m_l2addr, n_l2addr, m_faddr, n_faddr;
    bit            e_ack0, e_ack1;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_addr[i] = '0; end
        m_ptr = 0; m_slot = 0; m_trid = 0; m_last1 = 0; m_req = 0; m_done = 0;
        m_l2addr = '0; m_faddr = '0;
    endtask

    task automatic model_eval();
        int fi, win, ft, j;
        bit h0, h1, n0, n1, contested;
        logic [LW-1:0] aaddr;
        fi = -1; h0 = 0; h1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_st[i] == 0 && fi < 0) fi = i;
            if (m_st[i] != 0 && m_addr[i] == miss0_addr) h0 = 1;
            if (m_st[i] != 0 && m_addr[i] == miss1_addr) h1 = 1;
        end
        n0 = miss0_req && !h0;
        n1 = miss1_req && !h1;
        contested = n0 && n1 && (miss0_addr != miss1_addr);
        win = -1;
        if (fi >= 0) begin
            if (contested) win = m_last1 ? 0 : 1;
            else if (n0)   win = 0;
            else if (n1)   win = 1;
        end
        aaddr  = (win == 1) ? miss1_addr : miss0_addr;
        e_ack0 = miss0_req && (h0 || win == 0);
        e_ack1 = miss1_req && (h1 || win == 1 || (win == 0 && n1 && miss1_addr == miss0_addr));
        for (int i = 0; i < 4; i++) begin n_st[i] = m_st[i]; n_addr[i] = m_addr[i]; end
        n_ptr = m_ptr; n_slot = m_slot; n_trid = m_trid; n_last1 = m_last1; n_req = m_req;
        n_l2addr = m_l2addr; n_faddr = m_faddr; n_done = 0;
        ft = int'(fill_trid);
        if (fill_req && ft < 4 && m_st[ft] == 2) begin
            if (fill_resp[0]) begin n_st[ft] = 0; n_done = 1; n_faddr = m_addr[ft]; end
            else n_st[ft] = 1;
        end
        if (win >= 0) begin
            n_st[fi] = 1; n_addr[fi] = aaddr;
            if (contested) n_last1 = (win == 1);
        end
        if (m_req && l2_ack) n_st[m_slot] = 2;
        if (!m_req || l2_ack) begin
            n_req = 0;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!n_req && ((m_st[j] == 1 && !(m_req && j == m_slot)) || (win >= 0 && j == fi))) begin
                    n_req = 1; n_trid = j; n_slot = j; n_ptr = (j + 1) % 4;
                    n_l2addr = (win >= 0 && j == fi) ? aaddr : m_addr[j];
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 4; i++) begin m_st[i] = n_st[i]; m_addr[i] = n_addr[i]; end
        m_ptr = n_ptr; m_slot = n_slot; m_trid = n_trid; m_last1 = n_last1; m_req = n_req;
        m_l2addr = n_l2addr; m_faddr = n_faddr; m_done = n_done;
    endtask

    function automatic bit model_busy();
        for (int i = 0; i < 4; i++) if (m_st[i] != 0) return 1;
        return 0;
    endfunction

    task automatic settle();  #1; model_eval(); endtask
    task automatic advance(); @(posedge clk); #1; model_commit(); endtask

    task automatic set_idle();
        miss0_req = 0; miss1_req = 0; l2_ack = 0; fill_req = 0; fill_trid = '0; fill_resp = '0;
    endtask

    // Acknowledge and retire everything outstanding so the next scenario starts empty
    task automatic drain();
        int q[$];
        bit done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            set_idle(); l2_ack = 1;
            q.delete();
            for (int i = 0; i < 4; i++) if (m_st[i] == 2) q.push_back(i);
            if (q.size() > 0) begin fill_req = 1; fill_trid = 6'(q[0]); fill_resp = 3'b001; end
            settle(); advance();
            done = !model_busy() && !m_req;
        end
        set_idle();
        vectors++;
        if (!done || busy !== 1'b0) begin
            errors++; $display("FAIL drain: busy=%0b required 0 within 100 cycles", busy);
        end
    endtask

    task automatic test_reset();
        vectors += 6;
        if (l2_req !== 1'b0)    begin errors++; $display("FAIL reset_l2_req: got %0b expected 0", l2_req); end
        if (fill_done !== 1'b0) begin errors++; $display("FAIL reset_fill_done: got %0b expected 0", fill_done); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (l2_addr !== '0)     begin errors++; $display("FAIL reset_l2_addr: got %0h expected 0", l2_addr); end
        if (l2_trid !== '0)     begin errors++; $display("FAIL reset_l2_trid: got %0h expected 0", l2_trid); end
        if (fill_addr !== '0)   begin errors++; $display("FAIL reset_fill_addr: got %0h expected 0", fill_addr); end
        reset = 1;
        settle(); advance();
        vectors++;
        if (l2_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: l2_req=%0b busy=%0b expected 0 0", l2_req, busy);
        end
    endtask

    task automatic test_single_miss();
        miss0_req = 1; miss0_addr = 50'h100; l2_ack = 1;
        settle();
        vectors++;
        if (miss0_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %0b expected 1", miss0_ack); end
        advance();
        miss0_req = 0;
        vectors += 3;
        if (l2_req !== 1'b1)     begin errors++; $display("FAIL single_l2_req: got %0b expected 1", l2_req); end
        if (l2_addr !== 50'h100) begin errors++; $display("FAIL single_l2_addr: got %0h expected 100", l2_addr); end
        if (l2_trid !== 6'd0)    begin errors++; $display("FAIL single_l2_trid: got %0d expected 0", l2_trid); end
        settle(); advance();
        vectors++;
        if (l2_req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %0b expected 0", l2_req); end
        fill_req = 1; fill_trid = 6'd0; fill_resp = 3'b001;
        settle(); advance();
        set_idle();
        vectors += 3;
        if (fill_done !== 1'b1)    begin errors++; $display("FAIL single_fill_done: got %0b expected 1", fill_done); end
        if (fill_addr !== 50'h100) begin errors++; $display("FAIL single_fill_addr: got %0h expected 100", fill_addr); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL single_busy: got %0b expected 0", busy); end
        settle(); advance();
        vectors++;
        if (fill_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %0b expected 0", fill_done); end
    endtask

    task automatic test_dup_merge();
        miss0_req = 1; miss1_req = 1; miss0_addr = 50'h200; miss1_addr = 50'h200; l2_ack = 1;
        settle();
        vectors++;
        if (miss0_ack !== 1'b1 || miss1_ack !== 1'b1) begin
            errors++; $display("FAIL dup_acks: got %0b%0b expected 11", miss0_ack, miss1_ack);
        end
        advance();
        miss0_req = 0; miss1_req = 0;
        vectors++;
        if (l2_req !== 1'b1 || l2_addr !== 50'h200) begin
            errors++; $display("FAIL dup_issue: req=%0b addr=%0h expected 1 200", l2_req, l2_addr);
        end
        settle(); advance();
        vectors++;
        if (l2_req !== 1'b0) begin errors++; $display("FAIL dup_single_issue: got %0b expected 0", l2_req); end
        drain();
    endtask

    task automatic test_arbitration();
        miss0_req = 1; miss1_req = 1; miss0_addr = 50'h800; miss1_addr = 50'h801;
        settle();
        vectors++;
        if (miss0_ack !== 1'b0 || miss1_ack !== 1'b1) begin
            errors++; $display("FAIL arb_first: acks %0b%0b expected 01", miss0_ack, miss1_ack);
        end
        advance();
        miss1_addr = 50'h802;
        settle();
        vectors++;
        if (miss0_ack !== 1'b1 || miss1_ack !== 1'b0) begin
            errors++; $display("FAIL arb_second: acks %0b%0b expected 10", miss0_ack, miss1_ack);
        end
        advance();
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            miss0_req = 1; miss0_addr = 50'h300 + 50'(i);
            settle();
            vectors++;
            if (miss0_ack !== (i < 4)) begin
                errors++; $display("FAIL full_ack%0d: got %0b expected %0b", i, miss0_ack, (i < 4));
            end
            advance();
        end
        miss0_req = 0; l2_ack = 1;
        for (int c = 0; c < 5; c++) begin settle(); advance(); end
        l2_ack = 0; miss0_req = 1; miss0_addr = 50'h304;
        fill_req = 1; fill_trid = 6'd2; fill_resp = 3'b101;
        settle();
        vectors++;
        if (miss0_ack !== 1'b0) begin errors++; $display("FAIL full_same_cycle_free: got %0b expected 0", miss0_ack); end
        advance();
        fill_req = 0;
        vectors++;
        if (fill_done !== 1'b1 || fill_addr !== 50'h302) begin
            errors++; $display("FAIL full_fill: done=%0b addr=%0h expected 1 302", fill_done, fill_addr);
        end
        settle();
        vectors++;
        if (miss0_ack !== 1'b1) begin errors++; $display("FAIL full_realloc_ack: got %0b expected 1", miss0_ack); end
        advance();
        miss0_req = 0;
        vectors++;
        if (l2_req !== 1'b1 || l2_trid !== 6'd2 || l2_addr !== 50'h304) begin
            errors++; $display("FAIL full_realloc_issue: req=%0b trid=%0d addr=%0h expected 1 2 304", l2_req, l2_trid, l2_addr);
        end
        drain();
    endtask

    task automatic test_retry();
        logic [5:0] t;
        bit seen = 0;
        miss0_req = 1; miss0_addr = 50'h400; l2_ack = 1;
        settle(); advance();
        miss0_req = 0;
        t = l2_trid;
        vectors++;
        if (l2_trid !== 6'(m_trid)) begin errors++; $display("FAIL retry_trid: got %0d expected %0d", l2_trid, m_trid); end
        settle(); advance();
        l2_ack = 0; fill_req = 1; fill_trid = t; fill_resp = 3'b000;
        settle(); advance();
        fill_req = 0;
        vectors++;
        if (fill_done !== 1'b0) begin errors++; $display("FAIL retry_no_done: got %0b expected 0", fill_done); end
        for (int c = 0; c < 4 && !seen; c++) begin settle(); advance(); seen = l2_req; end
        vectors++;
        if (!seen || l2_addr !== 50'h400 || l2_trid !== t) begin
            errors++; $display("FAIL retry_reissue: req=%0b addr=%0h trid=%0d expected 1 400 %0d", l2_req, l2_addr, l2_trid, t);
        end
        l2_ack = 1;
        settle(); advance();
        l2_ack = 0; fill_req = 1; fill_trid = t; fill_resp = 3'b001;
        settle(); advance();
        fill_req = 0;
        vectors++;
        if (fill_done !== 1'b1 || fill_addr !== 50'h400) begin
            errors++; $display("FAIL retry_retire: done=%0b addr=%0h expected 1 400", fill_done, fill_addr);
        end
        drain();
    endtask

    task automatic test_stall_hold();
        logic [5:0] t0;
        miss0_req = 1; miss0_addr = 50'h500; l2_ack = 0;
        settle(); advance();
        miss0_req = 0; miss1_req = 1; miss1_addr = 50'h501;
        t0 = 6'(m_trid);
        settle();
        vectors++;
        if (miss1_ack !== 1'b1) begin errors++; $display("FAIL stall_ack1: got %0b expected 1", miss1_ack); end
        advance();
        miss1_req = 0;
        for (int c = 0; c < 3; c++) begin
            settle(); advance();
            vectors++;
            if (l2_req !== 1'b1 || l2_addr !== 50'h500 || l2_trid !== t0) begin
                errors++; $display("FAIL stall_hold%0d: req=%0b addr=%0h trid=%0d expected 1 500 %0d", c, l2_req, l2_addr, l2_trid, t0);
            end
        end
        l2_ack = 1;
        settle(); advance();
        vectors++;
        if (l2_req !== 1'b1 || l2_addr !== 50'h501 || l2_trid !== 6'(m_trid)) begin
            errors++; $display("FAIL stall_next: req=%0b addr=%0h trid=%0d expected 1 501 %0d", l2_req, l2_addr, l2_trid, m_trid);
        end
        drain();
    endtask

    task automatic test_random();
        int q[$];
        for (int c = 0; c < 400; c++) begin
            miss0_req  = ($urandom_range(0, 1) == 1);
            miss1_req  = ($urandom_range(0, 2) == 0);
            miss0_addr = 50'h700 + 50'($urandom_range(0, 5));
            miss1_addr = 50'h700 + 50'($urandom_range(0, 5));
            l2_ack     = ($urandom_range(0, 9) < 6);
            q.delete();
            for (int i = 0; i < 4; i++) if (m_st[i] == 2) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
                fill_req  = 1;
                fill_trid = 6'(q[$urandom_range(0, q.size() - 1)]);
                fill_resp = {2'($urandom), ($urandom_range(0, 3) != 0)};
            end else begin
                fill_req = 0; fill_trid = 6'($urandom); fill_resp = 3'($urandom);
            end
            settle();
            vectors += 2;
            if (miss0_ack !== e_ack0) begin errors++; $display("FAIL rnd_ack0 c%0d: got %0b expected %0b", c, miss0_ack, e_ack0); end
            if (miss1_ack !== e_ack1) begin errors++; $display("FAIL rnd_ack1 c%0d: got %0b expected %0b", c, miss1_ack, e_ack1); end
            advance();
            vectors += 5;
            if (l2_req !== m_req) begin errors++; $display("FAIL rnd_l2_req c%0d: got %0b expected %0b", c, l2_req, m_req); end
            if (l2_addr !== m_l2addr || l2_trid !== 6'(m_trid)) begin
                errors++; $display("FAIL rnd_l2_slot c%0d: got %0h/%0d expected %0h/%0d", c, l2_addr, l2_trid, m_l2addr, m_trid);
            end
            if (fill_done !== m_done) begin errors++; $display("FAIL rnd_fill_done c%0d: got %0b expected %0b", c, fill_done, m_done); end
            if (fill_addr !== m_faddr) begin errors++; $display("FAIL rnd_fill_addr c%0d: got %0h expected %0h", c, fill_addr, m_faddr); end
            if (busy !== model_busy()) begin errors++; $display("FAIL rnd_busy c%0d: got %0b expected %0b", c, busy, model_busy()); end
        end
        set_idle();
        drain();
    endtask

    task automatic test_reset_midway();
        int nsent = 0;
        l2_ack = 1;
        for (int i = 0; i < 3; i++) begin
            miss0_req = 1; miss0_addr = 50'h600 + 50'(i);
            settle(); advance();
        end
        miss0_req = 0;
        for (int c = 0; c < 4; c++) begin settle(); advance(); end
        l2_ack = 0; miss0_req = 1; miss0_addr = 50'h603;
        settle(); advance();
        miss0_req = 0;
        for (int i = 0; i < 4; i++) if (m_st[i] == 2) nsent++;
        vectors++;
        if (nsent != 3 || l2_req !== 1'b1) begin
            errors++; $display("FAIL midway_setup: sent=%0d l2_req=%0b expected 3 1", nsent, l2_req);
        end
        reset = 0;
        #1;
        vectors++;
        if (l2_req !== 1'b0 || fill_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midway_reset: req=%0b done=%0b busy=%0b expected 0 0 0", l2_req, fill_done, busy);
        end
        model_reset();
        #2 reset = 1;
        miss0_req = 1; miss0_addr = 50'h601;
        settle();
        vectors++;
        if (miss0_ack !== 1'b1) begin errors++; $display("FAIL midway_ack: got %0b expected 1", miss0_ack); end
        advance();
        miss0_req = 0;
        vectors++;
        if (l2_req !== 1'b1 || l2_trid !== 6'd0 || l2_addr !== 50'h601) begin
            errors++; $display("FAIL midway_realloc: req=%0b trid=%0d addr=%0h expected 1 0 601", l2_req, l2_trid, l2_addr);
        end
        drain();
    endtask

    initial begin
        reset = 0;
        set_idle();
        miss0_addr = '0; miss1_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_miss();
        test_dup_merge();
        test_arbitration();
        test_full();
        test_retry();
        test_stall_hold();
        test_random();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Miss/fill sequencer for the L1 instruction cache.
- Takes line misses from the two fetch read ports, merges duplicates and tracks them in a small miss table (MSHRs). Issues one line request per cycle toward L2 and retires entries when fills return.
- Sits between the fetch unit and the L2 request/response channel; the fill data itself goes straight into the L1 arrays and does not pass through this block.

Parameters:
- NPHYS, 56, physical address width.
- ACACHE_LINE_SIZE, 6, log2 of line bytes; line address is [NPHYS-1:ACACHE_LINE_SIZE].
- NMISS, 4, miss-table entries (power of two, 2..16).
- TRANS_ID_SIZE, 6, L2 transaction-id width; entry index is zero-extended into it.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset (asserted when 0).
- miss0_req  in  1  fetch port 0 line miss.
- miss0_addr  in  NPHYS-ACACHE_LINE_SIZE  port 0 line address.
- miss0_ack  out  1  port 0 miss accepted (allocated or merged), combinational.
- miss1_req  in  1  fetch port 1 line miss.
- miss1_addr  in  NPHYS-ACACHE_LINE_SIZE  port 1 line address.
- miss1_ack  out  1  port 1 miss accepted, combinational.
- l2_req  out  1  line request valid (registered).
- l2_addr  out  NPHYS-ACACHE_LINE_SIZE  requested line (registered).
- l2_trid  out  TRANS_ID_SIZE  transaction id (registered).
- l2_ack  in  1  L2 accepted the request this cycle.
- fill_req  in  1  fill response valid.
- fill_trid  in  TRANS_ID_SIZE  response id.
- fill_resp  in  3  bit0=data valid; bit0=0 means retry.
- fill_done  out  1  one-cycle pulse, line installed (registered).
- fill_addr  out  NPHYS-ACACHE_LINE_SIZE  address of installed line.
- busy  out  1  any entry not FREE.

Behaviour:
- Entry state per MSHR: FREE -> PEND (allocated, not yet sent) -> SENT (accepted by L2) -> FREE on valid fill. A retry fill (fill_resp[0]=0) moves SENT -> PEND and the line is re-requested.
- Matching: a miss address equal to any non-FREE entry's address is merged. The matching port gets ack=1 and nothing is allocated. A miss that matches the address of the entry retiring this same cycle is also merged and acked.
- Allocation:
  - At most one new entry per cycle, taken from the lowest-index FREE entry.
  - If both ports miss on different unmatched lines, port 0 wins when the last winner was port 1, else port 1 wins (1-bit round-robin). The loser gets ack=0 and re-presents the miss.
  - If both ports miss the same line, one allocation is made and both get ack=1.
- Full: no FREE entry means ack=0 for every unmatched miss; merges are still acked.
- An entry freed in cycle N can be allocated from cycle N+1 onward, never in N.
- Issue:
  - A registered request slot holds l2_req/l2_addr/l2_trid.
  - When the slot is empty, or l2_ack=1 this cycle, it loads the next PEND entry chosen by rotating priority starting at r_issue_ptr; r_issue_ptr then moves to the chosen index+1, wrapping modulo NMISS.
  - On l2_ack the entry goes to SENT. l2_addr and l2_trid hold stable while l2_req=1 and l2_ack=0.
  - Back-to-back issue runs at 1 request/cycle while l2_ack stays high.
  - A newly allocated entry can be issued at the earliest one cycle after allocation.
- Fill:
  - On fill_req=1 with a SENT entry at fill_trid and fill_resp[0]=1: the entry goes FREE and fill_done/fill_addr are registered for one cycle.
  - A fill to a non-SENT id is ignored; an assertion flags it in simulation.
- Simultaneous events: allocation, issue acceptance and fill retirement may all occur in the same cycle on different entries. A retry and an l2_ack on the same entry in the same cycle cannot occur, because the entry must be SENT to receive a fill.
- Reset:
  - All entries FREE; r_issue_ptr=0; round-robin=port 0.
  - l2_req=0, fill_done=0, busy=0; l2_addr/l2_trid/fill_addr=0.
  - Reset mid-transaction drops all outstanding state; L2 is reset in the same domain.

Decomposition:
- Shared package icache_pkg: entry-state enum (FREE/PEND/SENT), the line-address width expression, and the fill_resp bit-0 meaning.
- One natural sub-module, rr_pick: a rotating-priority one-hot picker (parameter N, inputs req vector and start pointer, outputs grant and index). It is reused for issue selection and also serves the free-entry find with start=0.

Test Plan:
- Port 0 misses 0x100 and l2_ack is tied 1: ack same cycle, l2_req with addr 0x100 and trid 0 one cycle later; fill trid 0 resp=1 -> fill_done with fill_addr 0x100 next cycle, busy=0.
- Both ports miss 0x200 in the same cycle -> both acked, exactly one request issued.
- With NMISS=4, five distinct misses on consecutive cycles and l2_ack held 0 -> fifth gets ack=0. Fill trid 2 -> fifth is accepted the cycle after fill_done, into entry 2.
- Retry: fill trid 1 with resp=0 -> entry re-requested with the same addr/trid; a later resp=1 retires it.
- Hold l2_ack=0 for 3 cycles -> l2_addr/l2_trid stable; on ack, the next PEND entry is issued the following cycle in rotating order.
- Pull reset low mid-way with 3 entries SENT -> l2_req, fill_done and busy drop to 0 immediately; after release, a miss to a previous address allocates entry 0.
